csr_access_ctrl: RTL and testbench

Writeback-side initiator for the control/status register file. It accepts one retiring CSR-class operation at a time from the pipeline: CSR read, CSR masked write, ERTN, exception, or a pending interrupt. It sequences the register file's read port, write port and exception/ERTN strobes. It returns the old CSR value to the register-writeback path and issues a one-cycle fetch redirect for ERTN and exceptions.

---
 rtl/csr_access_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl
// Writeback-side initiator for the CSR register file. Takes one retiring
// CSR-class operation at a time (read, masked write, ERTN, exception, or a
// pending interrupt). It sequences the register file read/write ports and
// the exception/ERTN commit strobes. It returns the old CSR value to
// writeback and issues a one-cycle fetch redirect for ERTN and exceptions.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | in_ready high, waiting for an operation
// READ    | csr_rnum presented, old value captured at end of cycle
// WRITE   | single-cycle csr_we pulse with the captured num/data/mask
// RESP    | out_valid held with old value until out_ready
// ERTN    | ertn_flush + flush_valid pulse, redirect to ex_ra
// EXC     | wb_ex + flush_valid pulse, redirect to ex_entry

module csr_access_ctrl (
    input  logic        clk,
    input  logic        resetn,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [13:0] in_csr_num,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_wmask,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_pc,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_dest,
    output logic [31:0] out_rdata,

    output logic        flush_valid,
    output logic [31:0] flush_pc,

    output logic [13:0] csr_rnum,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [13:0] csr_wnum,
    output logic [31:0] csr_wvalue,
    output logic [31:0] csr_wmask,

    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        ertn_flush,

    input  logic [31:0] ex_entry,
    input  logic [31:0] ex_ra,
    input  logic        has_int
);

    localparam logic [1:0] OP_RD   = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_ERTN = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_RESP  = 3'd3,
        S_ERTN  = 3'd4,
        S_EXC   = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_idle;
    logic        r_is_wr;
    logic [13:0] r_csr_num;
    logic [31:0] r_wdata;
    logic [31:0] r_wmask;
    logic [4:0]  r_dest;
    logic [31:0] r_rdata;
    logic        r_out_valid;
    logic        r_csr_we;
    logic        r_wb_ex;
    logic        r_ertn_flush;
    logic        r_flush_valid;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_wb_pc;
    logic [31:0] r_wb_vaddr;
    logic [31:0] w_flush_pc;

    // Sequencer: every strobe is registered alongside the state it belongs to,
    // so a strobe is high exactly while the FSM sits in its state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_idle        <= 1'b1;
            r_is_wr       <= 1'b0;
            r_csr_num     <= 14'h0;
            r_wdata       <= 32'h0;
            r_wmask       <= 32'h0;
            r_dest        <= 5'h0;
            r_rdata       <= 32'h0;
            r_out_valid   <= 1'b0;
            r_csr_we      <= 1'b0;
            r_wb_ex       <= 1'b0;
            r_ertn_flush  <= 1'b0;
            r_flush_valid <= 1'b0;
            r_ecode       <= 6'h0;
            r_esubcode    <= 9'h0;
            r_wb_pc       <= 32'h0;
            r_wb_vaddr    <= 32'h0;
        end else begin
            r_csr_we      <= 1'b0;
            r_wb_ex       <= 1'b0;
            r_ertn_flush  <= 1'b0;
            r_flush_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_idle <= 1'b0;
                        r_dest <= in_dest;
                        if (has_int) begin
                            // A pending interrupt takes the slot; the offered op is dropped.
                            r_state       <= S_EXC;
                            r_wb_ex       <= 1'b1;
                            r_flush_valid <= 1'b1;
                            r_ecode       <= 6'h00;
                            r_esubcode    <= 9'h000;
                            r_wb_pc       <= in_pc;
                            r_wb_vaddr    <= 32'h0;
                        end else begin
                            case (in_op)
                                OP_RD, OP_WR: begin
                                    r_state   <= S_READ;
                                    r_is_wr   <= (in_op == OP_WR);
                                    r_csr_num <= in_csr_num;
                                    r_wdata   <= in_wdata;
                                    r_wmask   <= in_wmask;
                                end
                                OP_ERTN: begin
                                    r_state       <= S_ERTN;
                                    r_ertn_flush  <= 1'b1;
                                    r_flush_valid <= 1'b1;
                                end
                                default: begin
                                    r_state       <= S_EXC;
                                    r_wb_ex       <= 1'b1;
                                    r_flush_valid <= 1'b1;
                                    r_ecode       <= in_wmask[5:0];
                                    r_esubcode    <= in_wmask[14:6];
                                    r_wb_pc       <= in_pc;
                                    r_wb_vaddr    <= in_wdata;
                                end
                            endcase
                        end
                    end
                end
                S_READ: begin
                    // Old value is latched before any write so writeback sees pre-write data.
                    r_rdata <= csr_rvalue;
                    if (r_is_wr) begin
                        r_state  <= S_WRITE;
                        r_csr_we <= 1'b1;
                    end else begin
                        r_state     <= S_RESP;
                        r_out_valid <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state     <= S_RESP;
                    r_out_valid <= 1'b1;
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_idle      <= 1'b1;
                    end
                end
                S_ERTN, S_EXC: begin
                    r_state <= S_IDLE;
                    r_idle  <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_idle      <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Redirect target follows the live return/entry address during the pulse only.
    always_comb begin
        w_flush_pc = 32'h0;
        if (r_ertn_flush)
            w_flush_pc = ex_ra;
        else if (r_wb_ex)
            w_flush_pc = ex_entry;
    end

    // in_ready stays low while resetn is asserted even though r_idle resets high.
    assign in_ready    = r_idle & resetn;
    assign out_valid   = r_out_valid;
    assign out_dest    = r_dest;
    assign out_rdata   = r_rdata;
    assign flush_valid = r_flush_valid;
    assign flush_pc    = w_flush_pc;
    assign csr_rnum    = r_csr_num;
    assign csr_we      = r_csr_we;
    assign csr_wnum    = r_csr_num;
    assign csr_wvalue  = r_wdata;
    assign csr_wmask   = r_wmask;
    assign wb_ex       = r_wb_ex;
    assign wb_ecode    = r_ecode;
    assign wb_esubcode = r_esubcode;
    assign wb_pc       = r_wb_pc;
    assign wb_vaddr    = r_wb_vaddr;
    assign ertn_flush  = r_ertn_flush;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Testbench for csr_access_ctrl: scoreboard of expected strobes/responses,
// with a behavioural CSR register file model supplying csr_rvalue.

module tb_csr_access_ctrl;

    localparam int K_RESP = 0;
    localparam int K_WE   = 1;
    localparam int K_EXC  = 2;
    localparam int K_ERTN = 3;

    typedef struct {
        int          kind;
        int          due;
        logic [13:0] num;
        logic [4:0]  dest;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] v3;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [13:0] in_csr_num;
    logic [31:0] in_wdata;
    logic [31:0] in_wmask;
    logic [4:0]  in_dest;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_dest;
    logic [31:0] out_rdata;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_wmask;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [31:0] ex_entry;
    logic [31:0] ex_ra;
    logic        has_int;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic prev_ov = 1'b0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];
    logic [31:0] csr_mem [0:63];

    csr_access_ctrl dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_csr_num(in_csr_num), .in_wdata(in_wdata), .in_wmask(in_wmask),
        .in_dest(in_dest), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
        .out_rdata(out_rdata),
        .flush_valid(flush_valid), .flush_pc(flush_pc),
        .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
        .csr_wnum(csr_wnum), .csr_wvalue(csr_wvalue), .csr_wmask(csr_wmask),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .ex_entry(ex_entry), .ex_ra(ex_ra), .has_int(has_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: combinational read, masked write on the clock edge.
    assign csr_rvalue = csr_mem[csr_rnum[5:0]];
    always @(posedge clk) begin
        if (resetn && csr_we)
            csr_mem[csr_wnum[5:0]] = (csr_mem[csr_wnum[5:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic pop_exp(input string tag, input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (sb.size() == 0) begin
            check_val({tag, "_unexpected"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_kind"}, e.kind, kind);
            ok = (e.kind == kind);
        end
    endtask

    // Monitor: sample mid-cycle and retire scoreboard entries as the DUT produces them.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!resetn) begin
            prev_ov = 1'b0;
        end else begin
            if (csr_we | wb_ex | ertn_flush)
                check_val("strobe_excl", $onehot({csr_we, wb_ex, ertn_flush}), 1);
            if (flush_valid != (wb_ex | ertn_flush))
                check_val("flush_pair", flush_valid, wb_ex | ertn_flush);
            if (csr_we) begin
                pop_exp("we", K_WE, e, ok);
                if (ok) begin
                    check_val("we_cycle", cyc, e.due);
                    check_val("we_num", csr_wnum, e.num);
                    check_val("we_value", csr_wvalue, e.v0);
                    check_val("we_mask", csr_wmask, e.v1);
                end
            end
            if (wb_ex) begin
                pop_exp("exc", K_EXC, e, ok);
                if (ok) begin
                    check_val("exc_cycle", cyc, e.due);
                    check_val("exc_pc", wb_pc, e.v0);
                    check_val("exc_vaddr", wb_vaddr, e.v1);
                    check_val("exc_code", {wb_esubcode, wb_ecode}, e.v2);
                    check_val("exc_flush_pc", flush_pc, e.v3);
                end
            end
            if (ertn_flush) begin
                pop_exp("ertn", K_ERTN, e, ok);
                if (ok) begin
                    check_val("ertn_cycle", cyc, e.due);
                    check_val("ertn_flush_pc", flush_pc, e.v3);
                end
            end
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) check_val("resp_unexpected", 1, 0);
                else begin
                    check_val("resp_first_kind", sb[0].kind, K_RESP);
                    check_val("resp_first_cycle", cyc, sb[0].due);
                end
            end
            if (out_valid && out_ready) begin
                pop_exp("resp", K_RESP, e, ok);
                if (ok) begin
                    check_val("resp_rdata", out_rdata, e.v0);
                    check_val("resp_dest", out_dest, e.dest);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [13:0] num, input logic [31:0] wd,
                         input logic [31:0] wm, input logic [4:0] dst, input logic [31:0] pc,
                         output int t_acc);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t_acc = -1;
        if (!in_ready) begin
            check_val("issue_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1; in_op = op; in_csr_num = num; in_wdata = wd;
        in_wmask = wm; in_dest = dst; in_pc = pc;
        t_acc = cyc + 1;
        e = '{default: 0};
        e.dest = dst;
        e.num  = num;
        if (has_int) begin
            e.kind = K_EXC; e.due = t_acc; e.v0 = pc; e.v1 = 32'h0; e.v2 = 32'h0; e.v3 = ex_entry;
            sb.push_back(e);
        end else if (op == 2'd0 || op == 2'd1) begin
            if (op == 2'd1) begin
                e.kind = K_WE; e.due = t_acc + 1; e.v0 = wd; e.v1 = wm;
                sb.push_back(e);
            end
            e.kind = K_RESP;
            e.due  = t_acc + ((op == 2'd1) ? 2 : 1);
            e.v0   = csr_mem[num[5:0]];
            sb.push_back(e);
        end else if (op == 2'd2) begin
            e.kind = K_ERTN; e.due = t_acc; e.v3 = ex_ra;
            sb.push_back(e);
        end else begin
            e.kind = K_EXC; e.due = t_acc; e.v0 = pc; e.v1 = wd;
            e.v2 = {17'h0, wm[14:0]}; e.v3 = ex_entry;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_op = 2'($urandom); in_csr_num = 14'($urandom); in_wdata = $urandom;
        in_wmask = $urandom; in_dest = 5'($urandom); in_pc = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_done", sb.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, n;
        logic [1:0] op;
        for (int i = 0; i < 64; i++) csr_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        csr_mem[6'h0c] = 32'h1234;
        csr_mem[6'h30] = 32'h5;
        resetn = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_csr_num = '0; in_wdata = '0;
        in_wmask = '0; in_dest = '0; in_pc = '0; out_ready = 1'b1; has_int = 1'b0;
        ex_entry = 32'h1c00_8000; ex_ra = 32'h1c00_0104;

        // Reset state
        #12;
        check_val("rst_in_ready_low", in_ready, 0);
        check_val("rst_outs_zero", |{out_valid, out_dest, out_rdata, flush_valid, flush_pc, csr_rnum,
                  csr_we, csr_wnum, csr_wvalue, csr_wmask, wb_ex, wb_ecode, wb_esubcode, wb_pc,
                  wb_vaddr, ertn_flush}, 0);
        @(negedge clk); resetn = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", in_ready, 1);

        // RD 0x0c with out_ready held low for 3 cycles
        out_ready = 1'b0;
        issue(2'd0, 14'h0c, 32'h0, 32'h0, 5'd7, 32'h1c00_0000, t1);
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 3; i++) begin
            check_val("rd_hold_valid", out_valid, 1);
            check_val("rd_hold_rdata", out_rdata, 32'h1234);
            check_val("rd_hold_dest", out_dest, 5'd7);
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        // WR 0x30: csr_we pulse carries wdata/wmask, response returns pre-write value
        issue(2'd1, 14'h30, 32'hdead_beef, 32'h0000_ffff, 5'd3, 32'h1c00_0010, t1);
        drain();
        check_val("wr_mem_after", csr_mem[6'h30], 32'h0000_beef);

        // EXC with ecode 0x09
        ex_entry = 32'h1c00_8000;
        issue(2'd3, 14'h0, 32'h1001, {17'h0, 9'h0, 6'h09}, 5'd0, 32'h1c00_0100, t1);
        drain();

        // Interrupt overrides an offered RD, then ERTN
        has_int = 1'b1;
        issue(2'd0, 14'h0c, 32'h0, 32'h0, 5'd9, 32'h1c00_0200, t1);
        has_int = 1'b0;
        ex_ra = 32'h1c00_0104;
        issue(2'd2, 14'h0, 32'h0, 32'h0, 5'd0, 32'h1c00_0204, t2);
        check_val("int_ertn_interval", t2 - t1, 2);
        drain();

        // Back-to-back minimum issue intervals
        issue(2'd2, 14'h0, 32'h0, 32'h0, 5'd0, 32'h0, t1);
        issue(2'd2, 14'h0, 32'h0, 32'h0, 5'd0, 32'h0, t2);
        check_val("ertn_interval", t2 - t1, 2);
        issue(2'd0, 14'h01, 32'h0, 32'h0, 5'd1, 32'h0, t1);
        issue(2'd0, 14'h02, 32'h0, 32'h0, 5'd2, 32'h0, t2);
        check_val("rd_interval", t2 - t1, 3);
        issue(2'd1, 14'h03, 32'h55, 32'hff, 5'd3, 32'h0, t1);
        issue(2'd1, 14'h04, 32'haa, 32'hf0f0, 5'd4, 32'h0, t2);
        check_val("wr_interval", t2 - t1, 4);
        drain();

        // Reset while csr_we is high
        issue(2'd1, 14'h20, 32'hffff_ffff, 32'hffff_ffff, 5'd5, 32'h0, t1);
        n = 0;
        while (!csr_we && n < 10) begin @(negedge clk); n++; end
        check_val("rst_mid_we_seen", csr_we, 1);
        #1 resetn = 1'b0;
        #1;
        check_val("rstw_outs_zero", |{out_valid, out_dest, out_rdata, flush_valid, flush_pc, csr_rnum,
                  csr_we, csr_wnum, csr_wvalue, csr_wmask, wb_ex, wb_ecode, wb_esubcode, wb_pc,
                  wb_vaddr, ertn_flush}, 0);
        check_val("rstw_in_ready", in_ready, 0);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rstw_no_we", csr_we, 0);
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rstw_idle_ready", in_ready, 1);
            check_val("rstw_idle_quiet", {csr_we, out_valid, flush_valid}, 0);
        end

        // Random traffic with random out_ready back-pressure
        rand_rdy = 1'b1;
        fork
            begin
                while (rand_rdy) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            has_int = ($urandom_range(0, 7) == 0);
            issue(op, 14'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom),
                  $urandom, t1);
        end
        has_int = 1'b0;
        rand_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
